// File: rtl/instr_encoder.sv
// instr_encoder: packs 2-bit SIC-4 instruction fields into 8-bit words and
// streams them into instruction memory, one word per accepted tuple.
//
// A load session opens on start_i (from idle or done), writes at
// auto-incrementing addresses from 0, and closes on a handshake with
// in_last_i set or after address DEPTH-1 has been written (full_o).
//
// Optional feature: define INSTR_ENC_CHECKSUM_EN to add checksum_o, the XOR
// of every word written in the current session.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   start_i              opens a session (honoured in idle or done only)
//   in_valid_i/in_ready_o  tuple handshake
//   in_op_i, in_rtd_i, in_rs_i, in_fun_imm_i  2-bit fields
//   in_last_i            accepted tuple is the last of the session
//   imem_we_o/imem_addr_o/imem_wdata_o  memory write port (registered)
//   busy_o, done_o, full_o, count_o      session status
//   checksum_o           session XOR (INSTR_ENC_CHECKSUM_EN only)

module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        in_op_i,
  input  logic [1:0]        in_rtd_i,
  input  logic [1:0]        in_rs_i,
  input  logic [1:0]        in_fun_imm_i,
  input  logic              in_last_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [7:0]        imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [7:0]        checksum_o
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                in_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [7:0]          imem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                full_q;
  logic [ADDR_W:0]     count_q;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [7:0]          checksum_q;
`endif

  logic [7:0] word;
  logic       handshake;
  logic       at_last_addr;

  assign word         = {in_op_i, in_rtd_i, in_rs_i, in_fun_imm_i};
  assign handshake    = in_valid_i && in_ready_q;
  assign at_last_addr = (ptr_q == LastAddr);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      count_q      <= '0;
`ifdef INSTR_ENC_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse per accepted tuple.
      imem_we_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          // in_valid_i is ignored here since in_ready_q is low.
          if (start_i) begin
            state_q    <= StLoad;
            ptr_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
            checksum_q <= '0;
`endif
          end
        end
        StLoad: begin
          if (handshake) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= ptr_q;
            imem_wdata_q <= word;
            ptr_q        <= ptr_q + 1'b1;  // wraps after DEPTH-1, unused thereafter
            count_q      <= count_q + 1'b1;
`ifdef INSTR_ENC_CHECKSUM_EN
            checksum_q   <= checksum_q ^ word;
`endif
            if (in_last_i || at_last_addr) begin
              state_q    <= StDone;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              full_q     <= at_last_addr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign full_o       = full_q;
  assign count_o      = count_q;
`ifdef INSTR_ENC_CHECKSUM_EN
  assign checksum_o   = checksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {addr, data}
// writes into queues, monitors pop and compare on every imem_we pulse.
// A second instance with ADDR_W = 2 covers the memory-full boundary.

module tb_instr_encoder;

  logic       clk;
  logic       rst;
  logic       start, start_s;
  logic       in_valid, in_valid_s;
  logic [1:0] op, rtd, rs, fi;
  logic       last;

  logic       in_ready, we, busy, done, full;
  logic [7:0] addr, wdata;
  logic [8:0] count;
  logic       in_ready_s, we_s, busy_s, done_s, full_s;
  logic [1:0] addr_s;
  logic [7:0] wdata_s;
  logic [2:0] count_s;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [7:0] checksum, checksum_s;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] q_main[$];
  logic [15:0] q_small[$];

  instr_encoder #(.ADDR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_op_i(op), .in_rtd_i(rtd), .in_rs_i(rs),
    .in_fun_imm_i(fi), .in_last_i(last), .imem_we_o(we), .imem_addr_o(addr),
    .imem_wdata_o(wdata), .busy_o(busy), .done_o(done), .full_o(full),
    .count_o(count)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum_o(checksum)
`endif
  );

  instr_encoder #(.ADDR_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start_s), .in_valid_i(in_valid_s),
    .in_ready_o(in_ready_s), .in_op_i(op), .in_rtd_i(rtd), .in_rs_i(rs),
    .in_fun_imm_i(fi), .in_last_i(last), .imem_we_o(we_s), .imem_addr_o(addr_s),
    .imem_wdata_o(wdata_s), .busy_o(busy_s), .done_o(done_s), .full_o(full_s),
    .count_o(count_s)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum_o(checksum_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare each write against the oldest expected entry.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (q_main.size() == 0) chk("main_unexpected_write", {24'h0, addr}, 32'hFFFF_FFFF);
      else begin
        logic [15:0] e;
        e = q_main.pop_front();
        chk("main_addr", {24'h0, addr}, {24'h0, e[15:8]});
        chk("main_wdata", {24'h0, wdata}, {24'h0, e[7:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (we_s === 1'b1) begin
      if (q_small.size() == 0) chk("small_unexpected_write", {30'h0, addr_s}, 32'hFFFF_FFFF);
      else begin
        logic [15:0] e;
        e = q_small.pop_front();
        chk("small_addr", {30'h0, addr_s}, {24'h0, e[15:8]});
        chk("small_wdata", {24'h0, wdata_s}, {24'h0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one tuple on the main instance for one cycle; push if it will be accepted.
  task automatic send(input logic [7:0] w, input logic l, input logic accept,
                      inout int exp_addr);
    {op, rtd, rs, fi} = w;
    last = l;
    in_valid = 1'b1;
    if (accept) begin
      q_main.push_back({exp_addr[7:0], w});
      exp_addr++;
    end
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_main(input string tag);
    chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
    chk({tag, "_we"}, {31'h0, we}, 32'h0);
    chk({tag, "_addr"}, {24'h0, addr}, 32'h0);
    chk({tag, "_wdata"}, {24'h0, wdata}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_full"}, {31'h0, full}, 32'h0);
    chk({tag, "_count"}, {23'h0, count}, 32'h0);
`ifdef INSTR_ENC_CHECKSUM_EN
    chk({tag, "_checksum"}, {24'h0, checksum}, 32'h0);
`endif
  endtask

  initial begin
    int a;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0;
    op = '0; rtd = '0; rs = '0; fi = '0; last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_main("reset");
    chk("reset_small_ready", {31'h0, in_ready_s}, 32'h0);

    // Single word with in_last.
    pulse_start();
    chk("start_in_ready", {31'h0, in_ready}, 32'h1);
    chk("start_busy", {31'h0, busy}, 32'h1);
    a = 0;
    send(8'h9C, 1'b1, 1'b1, a);
    in_valid = 1'b0; last = 1'b0;
    chk("single_we", {31'h0, we}, 32'h1);
    chk("single_done", {31'h0, done}, 32'h1);
    chk("single_busy", {31'h0, busy}, 32'h0);
    chk("single_ready", {31'h0, in_ready}, 32'h0);
    chk("single_count", {23'h0, count}, 32'd1);
    tick();
    chk("done_holds", {31'h0, done}, 32'h1);

    // In DONE: start together with in_valid -> only start acts.
    {op, rtd, rs, fi} = 8'hEE; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_count_clr", {23'h0, count}, 32'h0);
    chk("restart_done_clr", {31'h0, done}, 32'h0);

    // Five back-to-back tuples.
    a = 0;
    send(8'h11, 1'b0, 1'b1, a);
    send(8'h22, 1'b0, 1'b1, a);
    send(8'h33, 1'b0, 1'b1, a);
    send(8'h44, 1'b0, 1'b1, a);
    send(8'hA5, 1'b1, 1'b1, a);
    in_valid = 1'b0; last = 1'b0;
    chk("burst_count", {23'h0, count}, 32'd5);
    chk("burst_full", {31'h0, full}, 32'h0);
    chk("burst_done", {31'h0, done}, 32'h1);
    tick();

    // Toggled in_valid: idle cycles write nothing.
    pulse_start();
    a = 0;
    for (int i = 0; i < 4; i++) begin
      send(8'h50 + 8'(i), (i == 3), 1'b1, a);
      in_valid = 1'b0;
      if (i != 3) begin
        {op, rtd, rs, fi} = 8'hFF;
        tick();
      end
    end
    last = 1'b0;
    chk("toggle_count", {23'h0, count}, 32'd4);
    tick();

    // Memory-full boundary on the ADDR_W = 2 instance.
    start_s = 1'b1; tick(); start_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] w;
      w = 8'hC0 + 8'(i);
      {op, rtd, rs, fi} = w;
      in_valid_s = 1'b1;
      if (i < 4) q_small.push_back({8'(i), w});
      tick();
    end
    in_valid_s = 1'b0;
    chk("full_in_ready", {31'h0, in_ready_s}, 32'h0);
    chk("full_flag", {31'h0, full_s}, 32'h1);
    chk("full_count", {29'h0, count_s}, 32'd4);
    chk("full_done", {31'h0, done_s}, 32'h1);

    // Reset one cycle after the 2nd handshake.
    pulse_start();
    a = 0;
    send(8'h12, 1'b0, 1'b1, a);
    send(8'h34, 1'b0, 1'b1, a);
    // This cycle shows the write to address 1; the tuple below must not land.
    {op, rtd, rs, fi} = 8'h56;
    chk("rst_mid_we", {31'h0, we}, 32'h1);
    chk("rst_mid_addr", {24'h0, addr}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_main("midrst");
    for (int i = 0; i < 3; i++) tick();
    in_valid = 1'b0;
    chk("idle_holds_ready", {31'h0, in_ready}, 32'h0);
    chk("idle_holds_busy", {31'h0, busy}, 32'h0);

`ifdef INSTR_ENC_CHECKSUM_EN
    pulse_start();
    a = 0;
    send(8'h9C, 1'b0, 1'b1, a);
    send(8'h3F, 1'b0, 1'b1, a);
    send(8'h01, 1'b1, 1'b1, a);
    in_valid = 1'b0; last = 1'b0;
    chk("checksum_val", {24'h0, checksum}, 32'hA2);
    tick();
    pulse_start();
    chk("checksum_clr", {24'h0, checksum}, 32'h0);
    tick();
`endif

    tick(); tick();
    chk("main_queue_drained", q_main.size(), 32'd0);
    chk("small_queue_drained", q_small.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Packs 2-bit SIC-4 instruction fields (op, rtd, rs, fun_imm) into 8-bit instruction words.
- Writes those words one after another into instruction memory through a valid/ready input handshake.
- Sits between the test or host program source and the instruction memory write port; it is the inverse of the instruction decoder.
- A load session starts on `start`, auto-increments the address, and ends on `in_last` or when memory is full.

## Interface
- `ADDR_W`, default 8: instruction memory address width; DEPTH = 2**ADDR_W words.
- `clk`  in  1  rising-edge clock; the block has a single clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that opens a load session; honored only in IDLE or DONE.
- `in_valid`  in  1  field tuple on `in_*` is valid.
- `in_ready`  out  1  block can accept a tuple this cycle.
- `in_op`, `in_rtd`, `in_rs`, `in_fun_imm`  in  2 each  instruction fields.
- `in_last`  in  1  the tuple accepted this cycle is the final one in the session.
- `imem_we`  out  1  instruction memory write strobe, asserted for one cycle per word.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  8  packed word = {op, rtd, rs, fun_imm}; bits [7:6] = op, [5:4] = rtd, [3:2] = rs, [1:0] = fun_imm.
- `busy`  out  1  high in LOAD.
- `done`  out  1  high in DONE.
- `full`  out  1  session ended because address DEPTH-1 was written.
- `count`  out  ADDR_W+1  words written in the current or last session.
- `checksum`  out  8  present only under `INSTR_ENC_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset state is IDLE.
- IDLE:
  - `start` → LOAD; address pointer, `count`, `full` and checksum are cleared.
- LOAD:
  - `in_ready` = 1.
  - Handshake occurs when `in_valid` && `in_ready`.
  - On each handshake: latch packed word and current pointer into the output registers; pointer += 1; `count` += 1.
  - Handshake with `in_last` = 1 → DONE.
  - Handshake at pointer = DEPTH-1 → DONE with `full` = 1, whether or not `in_last` is set. The pointer wraps to 0 internally, but it is never used for a write in this session.
  - `start` in LOAD is ignored.
- DONE:
  - `in_ready` = 0.
  - `done` holds at 1 until `start` (→ LOAD, fresh session) or reset.
  - `count` and `full` hold their values.
- `in_*` inputs are ignored whenever `in_ready` = 0.
- Field widths are fixed at 2 bits. No field validation is done; all 256 encodings are legal.

## Timing
- Reset values: `in_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `busy` = 0, `done` = 0, `full` = 0, `count` = 0, `checksum` = 0.
- `in_ready` and `busy` go high the cycle after `start` is sampled.
- Write latency: a handshake at edge N gives `imem_we` = 1 with `imem_addr`/`imem_wdata` valid during cycle N+1. All outputs are registered.
- Throughput: one word per cycle while `in_valid` is held high.
- `done` rises in the same cycle as the `imem_we` of the final word.
- Reset in mid-session: at the next edge all outputs return to reset values. No partial write is issued after that edge.
- `start` and `in_valid` high together in IDLE or DONE: only `start` takes effect; the first handshake can happen one cycle later.

## Configuration
- `INSTR_ENC_CHECKSUM_EN` defined:
  - `checksum` port exists.
  - It is the XOR of every word written in the current session, updated in the same cycle as `imem_we`.
  - It is cleared on `start` and on reset.
- `INSTR_ENC_CHECKSUM_EN` undefined:
  - No `checksum` port and no checksum logic.
  - All other behaviour is identical.

## Test plan
- Reset, then `start`; handshake op=2'b10, rtd=2'b01, rs=2'b11, fun_imm=2'b00 with `in_last` = 1 → next cycle `imem_we` = 1, `imem_addr` = 0, `imem_wdata` = 8'h9C, `done` = 1, `count` = 1.
- Stream 5 tuples back-to-back, last with `in_last` = 1 → 5 consecutive `imem_we` pulses at addresses 0..4, `count` = 5, `full` = 0.
- Toggle `in_valid` 1/0 every cycle → writes occur only on accepted cycles and the address increments only on handshakes.
- `ADDR_W` = 2: stream 6 tuples without `in_last` → writes at addresses 0..3, then `in_ready` = 0, `full` = 1, `count` = 4; tuples 5 and 6 are not written.
- Assert `rst` in the cycle after the 2nd handshake of a session → that cycle shows the write to address 1; afterwards all outputs are at reset values and IDLE holds until `start`.
- With `INSTR_ENC_CHECKSUM_EN`: write 8'h9C, 8'h3F, 8'h01 → `checksum` = 8'hA2; a new `start` clears it to 8'h00.
